// File: rtl/life_sequencer.sv
// Game-of-Life generation sequencer: owns the grid register, commits next_grid at a timed rate or per step, halts on extinction/still life/limit.
// Commit lands eff_period cycles after entering RUN, or one cycle after step; no backpressure, all outputs registered.
module life_sequencer #(
    parameter int GRID_W = 256,
    parameter int DIV_W  = 24,
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] seed,
    input  logic              load,
    input  logic              run,
    input  logic              step,
    input  logic [DIV_W-1:0]  period,
    input  logic [GEN_W-1:0]  max_gens,
    input  logic [GRID_W-1:0] next_grid,
    output logic [GRID_W-1:0] grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic              busy,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic              update
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [GRID_W-1:0]  grid_q, grid_d;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic [DIV_W-1:0]   timer_q, timer_d;
    logic [1:0]         cause_q, cause_d;
    logic               update_q, update_d;

    logic [DIV_W-1:0]   period_m1;
    logic [GEN_W-1:0]   gen_inc;
    logic               do_commit;

    // A zero period behaves as one clock per generation.
    assign period_m1 = (period == '0) ? '0 : period - DIV_W'(1);
    assign gen_inc   = gen_q + GEN_W'(1);

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        gen_d     = gen_q;
        timer_d   = timer_q;
        cause_d   = cause_q;
        update_d  = 1'b0;
        do_commit = 1'b0;

        if (load) begin
            grid_d  = seed;
            gen_d   = '0;
            timer_d = '0;
            cause_d = 2'b00;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                    end else if (step) begin
                        state_d = ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (timer_q >= period_m1) begin
                        do_commit = 1'b1;
                        timer_d   = '0;
                    end else begin
                        timer_d = timer_q + DIV_W'(1);
                    end
                end
                ST_STEP: begin
                    do_commit = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: ;
            endcase

            if (do_commit) begin
                grid_d   = next_grid;
                gen_d    = (&gen_q) ? gen_q : gen_inc;
                update_d = 1'b1;
                // Halt priority: extinct, then still life, then limit.
                if (next_grid == '0) begin
                    cause_d = 2'b01;
                    state_d = ST_HALT;
                end else if (next_grid == grid_q) begin
                    cause_d = 2'b10;
                    state_d = ST_HALT;
                end else if ((max_gens != '0) && (gen_inc == max_gens)) begin
                    cause_d = 2'b11;
                    state_d = ST_HALT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grid_q   <= '0;
            gen_q    <= '0;
            timer_q  <= '0;
            cause_q  <= 2'b00;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            gen_q    <= gen_d;
            timer_q  <= timer_d;
            cause_q  <= cause_d;
            update_q <= update_d;
        end
    end

    assign grid       = grid_q;
    assign gen_count  = gen_q;
    assign busy       = (state_q == ST_RUN);
    assign halted     = (state_q == ST_HALT);
    assign halt_cause = cause_q;
    assign update     = update_q;

endmodule

// File: tb/tb_life_sequencer.sv
module tb_life_sequencer;

    localparam int GRID_W = 256;
    localparam int DIV_W  = 24;
    localparam int GEN_W  = 16;

    logic              clk = 1'b0;
    logic              reset, load, run, step;
    logic [GRID_W-1:0] seed, next_grid, grid;
    logic [DIV_W-1:0]  period;
    logic [GEN_W-1:0]  max_gens, gen_count;
    logic              busy, halted, update;
    logic [1:0]        halt_cause;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [GRID_W-1:0] grid;
        logic [GEN_W-1:0]  gen;
    } exp_t;
    exp_t sb_q[$];

    logic [GRID_W-1:0] blinker_h, blinker_v, block_p, single_p;

    life_sequencer #(.GRID_W(GRID_W), .DIV_W(DIV_W), .GEN_W(GEN_W)) dut (
        .clk(clk), .reset(reset), .seed(seed), .load(load), .run(run),
        .step(step), .period(period), .max_gens(max_gens),
        .next_grid(next_grid), .grid(grid), .gen_count(gen_count),
        .busy(busy), .halted(halted), .halt_cause(halt_cause), .update(update)
    );

    always #5 clk = ~clk;

    // Reference Life rule, dead cells beyond the border.
    function automatic logic [GRID_W-1:0] life_next(input logic [GRID_W-1:0] g);
        logic [GRID_W-1:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 16 && cc >= 0 && cc < 16)
                            cnt += int'(g[rr*16+cc]);
                    end
                end
                n[r*16+c] = g[r*16+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    assign next_grid = life_next(grid);

    // Scoreboard consumer: every update pulse must match the oldest expected commit.
    always @(posedge clk) begin
        #1;
        if (update === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_commit: gen_count=%0d grid=%h, required no commit", gen_count, grid);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (grid !== e.grid || gen_count !== e.gen) begin
                    failures++;
                    $display("FAIL sb_commit: grid=%h gen=%0d, required grid=%h gen=%0d", grid, gen_count, e.grid, e.gen);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [GRID_W-1:0] g, input logic [GEN_W-1:0] n);
        exp_t e;
        e.grid = g;
        e.gen  = n;
        sb_q.push_back(e);
    endtask

    task automatic do_load(input logic [GRID_W-1:0] s);
        seed = s;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b1; run = 1'b1; step = 1'b1;
        seed = {8{$urandom}}; period = 24'd3; max_gens = 16'd5;
        tick();
        tick();
        checks++;
        if (grid !== '0 || gen_count !== '0 || busy !== 1'b0 || halted !== 1'b0 ||
            halt_cause !== 2'b00 || update !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: grid=%h gen=%0d busy=%b halted=%b cause=%b update=%b, required all zero",
                     grid, gen_count, busy, halted, halt_cause, update);
        end
        reset = 1'b0; load = 1'b0; run = 1'b0; step = 1'b0;
        period = '0; max_gens = '0;
        tick();
    endtask

    task automatic test_step_blinker();
        do_load(blinker_h);
        for (int k = 1; k <= 2; k++) begin
            logic [GRID_W-1:0] want;
            want = (k == 1) ? blinker_v : blinker_h;
            push_exp(want, GEN_W'(k));
            step = 1'b1;
            tick();
            step = 1'b0;
            checks++;
            if (update !== 1'b0 || gen_count !== GEN_W'(k - 1)) begin
                failures++;
                $display("FAIL step_early: update=%b gen=%0d, required update=0 gen=%0d", update, gen_count, k - 1);
            end
            tick();
            checks++;
            if (grid !== want || gen_count !== GEN_W'(k) || update !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL step_commit%0d: grid=%h gen=%0d update=%b, required grid=%h gen=%0d update=1",
                         k, grid, gen_count, update, want, k);
            end
            tick();
            checks++;
            if (update !== 1'b0 || halted !== 1'b0) begin
                failures++;
                $display("FAIL step_pulse%0d: update=%b halted=%b, required 0 0", k, update, halted);
            end
        end
    endtask

    task automatic test_run_limit();
        logic [GRID_W-1:0] g;
        do_load(blinker_h);
        g = blinker_h;
        for (int k = 1; k <= 3; k++) begin
            g = life_next(g);
            push_exp(g, GEN_W'(k));
        end
        period = 24'd4; max_gens = 16'd3; run = 1'b1;
        tick();
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (update !== ((i % 4) == 0)) begin
                failures++;
                $display("FAIL run_timing: cycle=%0d update=%b, required %b", i, update, (i % 4) == 0);
            end
        end
        checks++;
        if (halted !== 1'b1 || halt_cause !== 2'b11 || busy !== 1'b0 || gen_count !== 16'd3) begin
            failures++;
            $display("FAIL run_limit_halt: halted=%b cause=%b busy=%b gen=%0d, required 1 11 0 3",
                     halted, halt_cause, busy, gen_count);
        end
        step = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        step = 1'b0; run = 1'b0;
        tick();
        checks++;
        if (halted !== 1'b1 || halt_cause !== 2'b11 || gen_count !== 16'd3 || grid !== g) begin
            failures++;
            $display("FAIL halt_hold: halted=%b cause=%b gen=%0d grid=%h, required 1 11 3 %h",
                     halted, halt_cause, gen_count, grid, g);
        end
    endtask

    task automatic test_still_life();
        do_load(block_p);
        period = 24'd0; max_gens = 16'd0; run = 1'b1;
        push_exp(block_p, 16'd1);
        tick();
        tick();
        checks++;
        if (update !== 1'b1 || gen_count !== 16'd1 || halted !== 1'b1 || halt_cause !== 2'b10 || grid !== block_p) begin
            failures++;
            $display("FAIL still_life: update=%b gen=%0d halted=%b cause=%b, required 1 1 1 10",
                     update, gen_count, halted, halt_cause);
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_extinct();
        do_load(single_p);
        max_gens = 16'd1;
        push_exp('0, 16'd1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        checks++;
        if (grid !== '0 || gen_count !== 16'd1 || halted !== 1'b1 || halt_cause !== 2'b01) begin
            failures++;
            $display("FAIL extinct: grid=%h gen=%0d halted=%b cause=%b, required 0 1 1 01",
                     grid, gen_count, halted, halt_cause);
        end
        max_gens = 16'd0;
        tick();
    endtask

    task automatic test_interrupts();
        do_load(blinker_h);
        period = 24'd10; max_gens = 16'd0; run = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        run = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || gen_count !== 16'd0 || grid !== blinker_h) begin
            failures++;
            $display("FAIL run_drop: busy=%b gen=%0d, required busy=0 gen=0 grid unchanged", busy, gen_count);
        end
        push_exp(blinker_v, 16'd1);
        run = 1'b1;
        tick();
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (update !== (i == 10)) begin
                failures++;
                $display("FAIL timer_restart: cycle=%0d update=%b, required %b", i, update, i == 10);
            end
        end
        for (int i = 0; i < 3; i++) tick();
        seed = single_p;
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (grid !== single_p || gen_count !== 16'd0 || busy !== 1'b0 || halted !== 1'b0 || update !== 1'b0) begin
            failures++;
            $display("FAIL load_mid_run: grid=%h gen=%0d busy=%b update=%b, required seed 0 0 0",
                     grid, gen_count, busy, update);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rerun_after_load: busy=%b, required 1", busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (grid !== '0 || gen_count !== '0 || busy !== 1'b0 || halted !== 1'b0 ||
            halt_cause !== 2'b00 || update !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_run: grid=%h gen=%0d busy=%b halted=%b cause=%b update=%b, required all zero",
                     grid, gen_count, busy, halted, halt_cause, update);
        end
        reset = 1'b0; run = 1'b0;
        tick();
    endtask

    initial begin
        blinker_h = '0; blinker_h[118] = 1'b1; blinker_h[119] = 1'b1; blinker_h[120] = 1'b1;
        blinker_v = '0; blinker_v[103] = 1'b1; blinker_v[119] = 1'b1; blinker_v[135] = 1'b1;
        block_p   = '0; block_p[119] = 1'b1; block_p[120] = 1'b1; block_p[135] = 1'b1; block_p[136] = 1'b1;
        single_p  = '0; single_p[119] = 1'b1;
        reset = 1'b0; load = 1'b0; run = 1'b0; step = 1'b0;
        seed = '0; period = '0; max_gens = '0;

        test_reset();
        test_step_blinker();
        test_run_limit();
        test_still_life();
        test_extinct();
        test_interrupts();

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: pending=%0d, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
Controller that sequences the 16x16 Game-of-Life generation datapath. The 256-bit grid is indexed as row*16+col.
- Owns the current-generation register and feeds it to the combinational next-generation datapath.
- Commits results at a programmable rate, or one step at a time on request.
- Counts generations and halts automatically on extinction, still life, or a generation limit.
- Sits between the top-level control/switch logic and the datapath/display.

Parameters:
GRID_W, 256, grid width in bits (16x16 cells)
DIV_W, 24, width of the generation-period timer
GEN_W, 16, width of the generation counter and limit

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
seed  in  GRID_W  initial pattern, captured on load
load  in  1  load seed into grid; highest priority after reset
run  in  1  level: free-run generations while high
step  in  1  pulse: advance exactly one generation from IDLE
period  in  DIV_W  clocks per generation in RUN; 0 treated as 1
max_gens  in  GEN_W  generation limit; 0 = unlimited
next_grid  in  GRID_W  datapath result computed from grid
grid  out  GRID_W  current registered generation, drives datapath and display
gen_count  out  GEN_W  generations committed since last load/reset
busy  out  1  high while in RUN
halted  out  1  high while in HALT
halt_cause  out  2  00 none, 01 extinct, 10 still life, 11 limit reached
update  out  1  one-cycle pulse on every grid commit

Behaviour:
- Reset (sync, at clk edge with reset=1) forces:
  - grid=0, gen_count=0, timer=0, halt_cause=00
  - update=0, state=IDLE
  - reset overrides load and every other input.
- States: IDLE, RUN, STEP, HALT. Outputs are registered:
  - busy = (state==RUN)
  - halted = (state==HALT)
- Commit action, applied in one cycle:
  - grid<=next_grid
  - gen_count<=gen_count+1, saturating at all-ones with no wrap
  - update<=1
  - halt check.
- Halt check, evaluated on the same commit, priority extinct > still > limit:
  - next_grid==0 -> cause 01
  - else next_grid==grid -> cause 10
  - else max_gens!=0 and gen_count+1==max_gens -> cause 11
  - if any condition hits, the commit still happens, then the next state is HALT.
- load=1 in any state (reset=0):
  - grid<=seed, gen_count<=0, timer<=0, halt_cause<=00, update<=0, next state IDLE
  - no commit that cycle.
- IDLE:
  - run=1 -> RUN with timer<=0
  - else step=1 -> STEP
  - else stay.
  - run has priority over step.
- RUN:
  - run=0 -> IDLE, timer<=0, no commit, even if the timer would expire.
  - Otherwise timer increments each cycle.
  - When timer >= eff_period-1, where eff_period = (period==0 ? 1 : period): commit and timer<=0.
  - The >= compare handles period shrinking mid-count: commit on the next cycle.
  - Commit latency: first commit lands eff_period cycles after entering RUN.
- STEP:
  - Commit unconditionally in this cycle, then go to IDLE, or HALT if the check fires.
  - step sampled in IDLE at edge N; commit at edge N+1; new grid visible after N+1.
  - step held high re-triggers once per IDLE visit, i.e. one generation every 2 cycles.
- HALT:
  - run and step are ignored; grid, gen_count and halt_cause hold.
  - Exit only via load or reset.
- update:
  - 1 for exactly the cycle after each commit edge, otherwise 0.
  - With period=1, update stays high continuously while commits occur every cycle.
- No combinational path from next_grid to any output.

Test Plan:
1. reset=1 for 2 cycles with arbitrary inputs -> grid=0, gen_count=0, busy=0, halted=0, halt_cause=00, update=0.
2. Blinker (bits 118,119,120):
   - load the seed, then pulse step one cycle -> two edges later grid has bits 103,119,135, gen_count=1, update high exactly one cycle.
   - Second step -> grid back to bits 118,119,120, gen_count=2.
3. Blinker, period=4, max_gens=3, run=1 held:
   - commits at 4, 8, 12 cycles after entering RUN; gen_count 1,2,3.
   - After the third commit: halted=1, halt_cause=11, busy=0.
   - Further run/step cause no change.
4. Block still life (bits 119,120,135,136), period=0, run=1 -> commit on first RUN cycle, gen_count=1, halt_cause=10, grid unchanged.
5. Single cell (bit 119), step -> grid=0, gen_count=1, halt_cause=01 (extinct wins even if max_gens=1).
6. Interruptions during RUN with period=10:
   - Drop run after 5 cycles -> IDLE, no commit, timer restarts at 0 on next run.
   - load mid-RUN -> grid=seed, gen_count=0, IDLE.
   - reset mid-RUN -> all-zero outputs on the next edge.
